// File: rtl/neo_pixel_strand_receiver.sv
// WS2812-style strand receiver: times each high pulse to recover bits, packs
// 24-bit GRB words and detects the long-low frame latch.
module neo_pixel_strand_receiver #(
  parameter int T1_MIN_HIGH = 26,
  parameter int MAX_HIGH    = 50,
  parameter int RESET_LOW   = 2500,
  parameter int NUM_PIXELS  = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       neo_data,
  output logic       pixel_valid,
  output logic [2:0] pixel_index,
  output logic [7:0] green,
  output logic [7:0] red,
  output logic [7:0] blue,
  output logic       frame_done,
  output logic       frame_error,
  output logic [3:0] pixels_received
);
  localparam int HW = $clog2(MAX_HIGH + 2);
  localparam int LW = $clog2(RESET_LOW + 1);
  localparam int PW = $clog2(NUM_PIXELS + 1);
  localparam logic [HW-1:0] T1_C   = HW'(T1_MIN_HIGH);
  localparam logic [HW-1:0] HMAX_C = HW'(MAX_HIGH);
  localparam logic [LW-1:0] LMAX_C = LW'(RESET_LOW);
  localparam logic [PW-1:0] PMAX_C = PW'(NUM_PIXELS);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_ERROR} state_t;

  state_t        state_q, state_d;
  logic          d_q, d_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [4:0]    bitcnt_q, bitcnt_d;
  logic [PW-1:0] pixcnt_q, pixcnt_d;
  logic [23:0]   sr_q, sr_d;
  logic          pixel_valid_q, pixel_valid_d;
  logic [2:0]    pixel_index_q, pixel_index_d;
  logic [7:0]    green_q, green_d, red_q, red_d, blue_q, blue_d;
  logic          frame_done_q, frame_done_d;
  logic          frame_error_q, frame_error_d;
  logic [3:0]    pixels_received_q, pixels_received_d;

  logic [23:0]   sr_shift;
  logic [LW-1:0] lcnt_inc;
  assign sr_shift = {sr_q[22:0], (hcnt_q >= T1_C)};
  assign lcnt_inc = (&lcnt_q) ? lcnt_q : lcnt_q + LW'(1);

  always_comb begin
    state_d           = state_q;
    d_d               = neo_data;
    hcnt_d            = hcnt_q;
    lcnt_d            = lcnt_q;
    bitcnt_d          = bitcnt_q;
    pixcnt_d          = pixcnt_q;
    sr_d              = sr_q;
    pixel_valid_d     = 1'b0;
    pixel_index_d     = pixel_index_q;
    green_d           = green_q;
    red_d             = red_q;
    blue_d            = blue_q;
    frame_done_d      = 1'b0;
    frame_error_d     = 1'b0;
    pixels_received_d = pixels_received_q;
    case (state_q)
      S_IDLE: begin
        if (d_q) begin
          state_d = S_HIGH;
          hcnt_d  = HW'(1);
        end
      end
      S_HIGH: begin
        if (d_q) begin
          if (hcnt_q >= HMAX_C) begin
            state_d       = S_ERROR;
            frame_error_d = 1'b1;
            lcnt_d        = '0;
          end else begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end else begin
          sr_d    = sr_shift;
          state_d = S_LOW;
          lcnt_d  = LW'(1);
          if (bitcnt_q == 5'd23) begin
            bitcnt_d = '0;
            if (pixcnt_q < PMAX_C) begin
              pixel_valid_d = 1'b1;
              pixel_index_d = 3'(pixcnt_q);
              green_d       = sr_shift[23:16];
              red_d         = sr_shift[15:8];
              blue_d        = sr_shift[7:0];
              pixcnt_d      = pixcnt_q + PW'(1);
            end else begin
              // one word too many for this strand: treat as a broken frame
              state_d       = S_ERROR;
              frame_error_d = 1'b1;
            end
          end else begin
            bitcnt_d = bitcnt_q + 5'd1;
          end
        end
      end
      S_LOW: begin
        if (d_q) begin
          state_d = S_HIGH;
          hcnt_d  = HW'(1);
        end else begin
          lcnt_d = lcnt_inc;
          if (lcnt_inc >= LMAX_C) begin
            frame_done_d      = 1'b1;
            frame_error_d     = (bitcnt_q != '0);
            pixels_received_d = 4'(pixcnt_q);
            pixcnt_d          = '0;
            bitcnt_d          = '0;
            sr_d              = '0;
            state_d           = S_IDLE;
          end
        end
      end
      S_ERROR: begin
        // wait out a full latch-length low before trusting the wire again
        if (d_q) begin
          lcnt_d = '0;
        end else begin
          lcnt_d = lcnt_inc;
          if (lcnt_inc >= LMAX_C) begin
            lcnt_d   = '0;
            hcnt_d   = '0;
            pixcnt_d = '0;
            bitcnt_d = '0;
            sr_d     = '0;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q           <= S_IDLE;
      d_q               <= 1'b0;
      hcnt_q            <= '0;
      lcnt_q            <= '0;
      bitcnt_q          <= '0;
      pixcnt_q          <= '0;
      sr_q              <= '0;
      pixel_valid_q     <= 1'b0;
      pixel_index_q     <= '0;
      green_q           <= '0;
      red_q             <= '0;
      blue_q            <= '0;
      frame_done_q      <= 1'b0;
      frame_error_q     <= 1'b0;
      pixels_received_q <= '0;
    end else begin
      state_q           <= state_d;
      d_q               <= d_d;
      hcnt_q            <= hcnt_d;
      lcnt_q            <= lcnt_d;
      bitcnt_q          <= bitcnt_d;
      pixcnt_q          <= pixcnt_d;
      sr_q              <= sr_d;
      pixel_valid_q     <= pixel_valid_d;
      pixel_index_q     <= pixel_index_d;
      green_q           <= green_d;
      red_q             <= red_d;
      blue_q            <= blue_d;
      frame_done_q      <= frame_done_d;
      frame_error_q     <= frame_error_d;
      pixels_received_q <= pixels_received_d;
    end
  end

  assign pixel_valid     = pixel_valid_q;
  assign pixel_index     = pixel_index_q;
  assign green           = green_q;
  assign red             = red_q;
  assign blue            = blue_q;
  assign frame_done      = frame_done_q;
  assign frame_error     = frame_error_q;
  assign pixels_received = pixels_received_q;
endmodule
